adder_sequencer: RTL and testbench
==================================

// Module: adder_sequencer
// PURPOSE
//  Multi-cycle controller that performs WIDTH = 4*NIBBLES-bit add/subtract using ONE shared
//  FullAdder4bit (sum, carryout, overflow, a, b; no carry-in). It walks the operands nibble by
//  nibble and injects carry-in as an extra "+1" pass through the same adder. It sits between a
//  requester (valid/ready) and a consumer (valid/ready), and is the sequencer for the 4-bit datapath.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices; result width = 4*NIBBLES (NIBBLES >= 1)
// PORTS
//  clk          in   1            single clock; all state updates on posedge clk
//  reset        in   1            synchronous, active-high; one clock, sync active-high reset
//  start_valid  in   1            request present
//  start_ready  out  1            high only in IDLE; accept when start_valid & start_ready
//  op_a         in   4*NIBBLES    operand A (two's complement)
//  op_b         in   4*NIBBLES    operand B (two's complement)
//  sub          in   1            1: A-B (B inverted, initial carry 1); 0: A+B
//  done_valid   out  1            result valid; held until done_ready
//  done_ready   in   1            consumer accepts on done_valid & done_ready
//  result       out  4*NIBBLES    sum/difference
//  carryout     out  1            carry out of MSB nibble
//  overflow     out  1            signed overflow of full-width op
//  busy         out  1            high in ADD or INC
// BEHAVIOUR
//  Reset: state=IDLE; start_ready=1 (comb from IDLE); done_valid, busy, result, carryout, overflow all 0.
//  Reset beats every other input. Reset mid-operation discards the operation: IDLE on the next edge, no done_valid.
//  States: IDLE, ADD, INC, DONE (binary-encoded, 2 bits).
//   IDLE: on accept, latch A and B' (B' = sub ? ~op_b : op_b), set cin=sub, idx=0, clear result -> ADD.
//     op_a/op_b/sub are sampled only at accept; later changes are ignored.
//   ADD: adder a=A[idx], b=B'[idx]; register s=sum and c1=carryout.
//     If cin=1 -> INC.
//     Else write result[idx]=sum, cin=c1, idx++; if idx was NIBBLES-1 -> DONE, else stay in ADD.
//   INC: adder a=s, b=4'b0001; write result[idx]=sum, cin=c1|carryout, idx++.
//     c1 and the INC carry are never both 1.
//     If idx was NIBBLES-1 -> DONE, else -> ADD.
//   DONE: done_valid=1; result, carryout and overflow held stable.
//     On done_ready -> IDLE (done_valid drops on the same edge).
//     start_valid is ignored in DONE and while busy.
//  carryout = final cin after the last nibble.
//  overflow = (A[msb]==B'[msb]) & (result[msb]!=A[msb]).
//  The adder's own overflow output is not used.
//  Latency: accept at edge k; done_valid is high after edge k+NIBBLES+n_inc.
//   n_inc = number of nibbles entered with cin=1 (range 0..NIBBLES).
//   Bounds: min NIBBLES, max 2*NIBBLES.
//  Wrap-around: result is modulo 2^(4*NIBBLES); no saturation.
//  Back-to-back: the earliest new accept is the cycle after the done handshake (IDLE cycle).
//  Throughput: at most one op per NIBBLES+2 cycles.
// STRUCTURE
//  Shared defs header adder_seq_defs.v: state encodings S_IDLE=0, S_ADD=1, S_INC=2, S_DONE=3; NIB_W=4.
//  Exactly one FullAdder4bit instance, its inputs muxed by state (ADD: operand nibbles; INC: s/0001).
//  Nibble select via idx*4 part-select.
//  No further sub-module: FSM, idx counter, and A/B'/result/s/cin registers live in this module.
// TESTING (NIBBLES=4; latency counted in edges after the accept edge)
//  1. 0x0001+0x0002, sub=0 -> 0x0003, cout=0, ovf=0, done_valid after 4 edges (no INC).
//  2. 0xFFFF+0x0001 -> 0x0000, cout=1, ovf=0, 7 edges (INC on nibbles 1..3).
//  3. 0x7FFF+0x0001 -> 0x8000, cout=0, ovf=1.
//     Also sub 0x8000-0x0001 -> 0x7FFF, ovf=1.
//  4. sub 0x0005-0x0007 -> 0xFFFE, cout=0, ovf=0, 5 edges.
//     Also sub 0x0007-0x0007 -> 0x0000, cout=1.
//  5. Hold done_ready=0 for 10 cycles while toggling start_valid and operands:
//     result/flags stable, start_ready=0, no second accept.
//     Then done_ready=1 -> IDLE; next request accepted one cycle later.
//  6. Assert reset for 1 cycle during ADD of idx=2:
//     next cycle IDLE, done_valid=0, outputs 0, start_ready=1; a fresh 0x1234+0x1111 -> 0x2345.

Source files
------------

// File: rtl/adder_sequencer_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package adder_sequencer_pkg;

  localparam int unsigned NibW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StInc  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/adder_sequencer_if.sv
// Request/result handshake bundle between a requester/consumer and the sequencer.
interface adder_sequencer_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         busy;

  modport master (
    output start_valid, op_a, op_b, sub, done_ready,
    input  start_ready, done_valid, result, carryout, overflow, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, sub, done_ready,
    output start_ready, done_valid, result, carryout, overflow, busy
  );

endinterface

// File: rtl/adder_sequencer_fa4.sv
// 4-bit adder without carry-in: sum, carry out and signed overflow of the slice.
module adder_sequencer_fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       carryout,
  output logic       overflow
);

  assign {carryout, sum} = {1'b0, a} + {1'b0, b};
  assign overflow        = (a[3] == b[3]) & (sum[3] != a[3]);

endmodule

// File: rtl/adder_sequencer.sv
// Multi-cycle add/subtract that walks the operands one nibble at a time through a single
// 4-bit adder, applying carry-in as an extra +1 pass.
module adder_sequencer
  import adder_sequencer_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  adder_sequencer_if.slave bus
);

  localparam int unsigned W    = NibW * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      result_q;
  logic [NibW-1:0]   s_q;
  logic              cin_q;
  logic              c1_q;
  logic              carry_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;

  logic [31:0]       base;
  logic              last;
  logic [NibW-1:0]   fa_a;
  logic [NibW-1:0]   fa_b;
  logic [NibW-1:0]   fa_sum;
  logic              fa_cout;
  logic              fa_ovf_unused;
  logic              wr_cout;
  logic              ovf_next;

  always_comb begin
    base = 32'(idx_q) * NibW;
    last = (idx_q == IdxW'(NIBBLES - 1));
    fa_a = a_q[base +: NibW];
    fa_b = b_q[base +: NibW];
    if (state_q == StInc) begin
      fa_a = s_q;
      fa_b = 4'b0001;
    end
    // c1 and the +1 carry are mutually exclusive, so OR is the combined carry
    wr_cout  = (state_q == StInc) ? (c1_q | fa_cout) : fa_cout;
    ovf_next = (a_q[W-1] == b_q[W-1]) & (fa_sum[NibW-1] != a_q[W-1]);
  end

  adder_sequencer_fa4 u_fa4 (
    .a        (fa_a),
    .b        (fa_b),
    .sum      (fa_sum),
    .carryout (fa_cout),
    .overflow (fa_ovf_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      s_q      <= '0;
      cin_q    <= 1'b0;
      c1_q     <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_valid) begin
            a_q      <= bus.op_a;
            b_q      <= bus.sub ? ~bus.op_b : bus.op_b;
            cin_q    <= bus.sub;
            idx_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StAdd;
          end
        end
        StAdd, StInc: begin
          if (state_q == StAdd) begin
            s_q  <= fa_sum;
            c1_q <= fa_cout;
          end
          if (state_q == StAdd && cin_q) begin
            state_q <= StInc;
          end else begin
            result_q[base +: NibW] <= fa_sum;
            cin_q                  <= wr_cout;
            idx_q                  <= idx_q + 1'b1;
            if (last) begin
              carry_q <= wr_cout;
              ovf_q   <= ovf_next;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StAdd;
            end
          end
        end
        StDone: begin
          if (bus.done_ready) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.start_ready = (state_q == StIdle);
  assign bus.done_valid  = done_q;
  assign bus.busy        = busy_q;
  assign bus.result      = result_q;
  assign bus.carryout    = carry_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Directed bench for adder_sequencer with NIBBLES=4 and hand-computed expectations.
module tb_adder_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  adder_sequencer_if #(.NIBBLES(4)) bus ();

  adder_sequencer #(.NIBBLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accept edge until done_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    check_eq("start_ready_before", 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.sub         = s;
    tick();
    bus.start_valid = 1'b0;
    check_eq("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] exp_res, input logic exp_c,
                       input logic exp_v, input int exp_lat);
    int lat;
    start_op(a, b, s);
    wait_done(lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    check_eq({tag, "_carry"}, 32'(bus.carryout), 32'(exp_c));
    check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_v));
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    check_eq({tag, "_done_drop"}, 32'(bus.done_valid), 32'd0);
  endtask

  initial begin
    int lat;
    n_checks        = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.start_valid = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.sub         = 1'b0;
    bus.done_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check_eq("rst_done_valid", 32'(bus.done_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_result", 32'(bus.result), 32'd0);
    check_eq("rst_flags", {30'd0, bus.carryout, bus.overflow}, 32'd0);

    do_op("add_small", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 4);
    do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 7);
    do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 7);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 5);
    do_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 5);
    do_op("sub_zero", 16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0, 8);

    // Result held under backpressure while the requester keeps poking.
    start_op(16'h1234, 16'h0001, 1'b0);
    wait_done(lat);
    check_eq("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      bus.start_valid = i[0];
      bus.op_a        = 16'(i * 16'h1111);
      bus.op_b        = 16'(i);
      bus.sub         = i[1];
      tick();
      check_eq("bp_result", 32'(bus.result), 32'h1235);
      check_eq("bp_done_valid", 32'(bus.done_valid), 32'd1);
      check_eq("bp_start_ready", 32'(bus.start_ready), 32'd0);
      check_eq("bp_flags", {30'd0, bus.carryout, bus.overflow}, 32'd0);
    end
    bus.start_valid = 1'b1;
    bus.op_a        = 16'h0002;
    bus.op_b        = 16'h0003;
    bus.sub         = 1'b0;
    bus.done_ready  = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    check_eq("bp_idle_ready", 32'(bus.start_ready), 32'd1);
    check_eq("bp_idle_done", 32'(bus.done_valid), 32'd0);
    tick();
    bus.start_valid = 1'b0;
    check_eq("bp_next_busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    check_eq("bp_next_latency", 32'(lat), 32'd4);
    check_eq("bp_next_result", 32'(bus.result), 32'h0005);
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;

    // Reset while nibble 2 is being added.
    start_op(16'h1111, 16'h1111, 1'b0);
    tick();
    tick();
    check_eq("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_start_ready", 32'(bus.start_ready), 32'd1);
    check_eq("mid_done_valid", 32'(bus.done_valid), 32'd0);
    check_eq("mid_busy_clr", 32'(bus.busy), 32'd0);
    check_eq("mid_result", 32'(bus.result), 32'd0);
    check_eq("mid_flags", {30'd0, bus.carryout, bus.overflow}, 32'd0);
    tick();
    tick();
    tick();
    check_eq("mid_no_done", 32'(bus.done_valid), 32'd0);
    do_op("post_reset", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
